// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline stages (master) and hazard_ctrl (slave).
// The perf-counter signals exist only when HAZ_PERF_CNT_EN is defined.
interface hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic [REG_AW-1:0] Rs1_D;
    logic [REG_AW-1:0] Rs2_D;
    logic [REG_AW-1:0] Rs1_E;
    logic [REG_AW-1:0] Rs2_E;
    logic [REG_AW-1:0] Rd_E;
    logic [REG_AW-1:0] Rd_M;
    logic [REG_AW-1:0] Rd_W;
    logic              LoadE;
    logic              RegWriteM;
    logic              RegWriteW;
    logic              PCSrcE;
    logic              McStartE;
    logic [1:0]        ForwardAE;
    logic [1:0]        ForwardBE;
    logic              StallF;
    logic              StallD;
    logic              StallE;
    logic              FlushD;
    logic              FlushE;
    logic              BubbleM;
    logic              McBusy;
    logic              McDoneE;
`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0]  stall_cycles;
    logic [CNT_W-1:0]  flush_events;
`endif

    if (REG_AW < 1 || CNT_W < 1) begin : g_bad_param
        $error("hazard_ctrl_if: REG_AW and CNT_W must be positive");
    end

    modport master (
        output Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W,
        output LoadE, RegWriteM, RegWriteW, PCSrcE, McStartE,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE,
        input  FlushD, FlushE, BubbleM, McBusy, McDoneE
`ifdef HAZ_PERF_CNT_EN
        , input stall_cycles, flush_events
`endif
    );

    modport slave (
        input  Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W,
        input  LoadE, RegWriteM, RegWriteW, PCSrcE, McStartE,
        output ForwardAE, ForwardBE, StallF, StallD, StallE,
        output FlushD, FlushE, BubbleM, McBusy, McDoneE
`ifdef HAZ_PERF_CNT_EN
        , output stall_cycles, flush_events
`endif
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard unit for the 5-stage pipeline: forwarding, load-use stall, branch flush,
// multi-cycle execute sequencer. Define HAZ_PERF_CNT_EN for stall/flush perf counters.
module hazard_ctrl #(
    parameter int REG_AW     = 5,
    parameter int MC_LATENCY = 4,
    parameter int CNT_W      = 32
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;
    localparam logic [7:0] MC_LOAD = 8'(MC_LATENCY - 1);
    localparam logic [REG_AW-1:0] X0 = {REG_AW{1'b0}};

    if (MC_LATENCY < 2 || MC_LATENCY > 255 || CNT_W < 1 || REG_AW < 1) begin : g_bad_param
        $error("hazard_ctrl: parameter out of range");
    end

    logic [0:0] state_r;
    logic [7:0] cnt_r;
    logic [1:0] fwd_a_s;
    logic [1:0] fwd_b_s;
    logic       lw_stall_s;
    logic       mc_stall_s;
    logic       mc_done_s;
    logic       stall_f_s;
    logic       stall_e_s;
    logic       flush_d_s;
    logic       flush_e_s;
    logic       busy_s;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rd_m,
        input logic [REG_AW-1:0] rd_w,
        input logic              we_m,
        input logic              we_w
    );
        logic [1:0] sel;
        if (we_m && (rd_m != X0) && (rd_m == rs)) begin
            sel = 2'b10;
        end else if (we_w && (rd_w != X0) && (rd_w == rs)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Sequencer state: the countdown holds E for MC_LATENCY cycles in total
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (hz.McStartE) begin
                        state_r <= ST_BUSY;
                        cnt_r   <= MC_LOAD;
                    end else begin
                        state_r <= ST_IDLE;
                        cnt_r   <= 8'd0;
                    end
                end
                ST_BUSY: begin
                    if (cnt_r > 8'd1) begin
                        state_r <= ST_BUSY;
                        cnt_r   <= cnt_r - 8'd1;
                    end else begin
                        state_r <= ST_IDLE;
                        cnt_r   <= 8'd0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 8'd0;
                end
            endcase
        end
    end

    // Hazard decode; reset forces every control to its inactive value
    always_comb begin
        fwd_a_s    = 2'b00;
        fwd_b_s    = 2'b00;
        lw_stall_s = 1'b0;
        mc_stall_s = 1'b0;
        mc_done_s  = 1'b0;
        busy_s     = 1'b0;
        if (rst) begin
            fwd_a_s    = 2'b00;
            fwd_b_s    = 2'b00;
            lw_stall_s = 1'b0;
            mc_stall_s = 1'b0;
            mc_done_s  = 1'b0;
            busy_s     = 1'b0;
        end else begin
            fwd_a_s    = fwd_sel(hz.Rs1_E, hz.Rd_M, hz.Rd_W, hz.RegWriteM, hz.RegWriteW);
            fwd_b_s    = fwd_sel(hz.Rs2_E, hz.Rd_M, hz.Rd_W, hz.RegWriteM, hz.RegWriteW);
            lw_stall_s = hz.LoadE && (hz.Rd_E != X0)
                         && ((hz.Rd_E == hz.Rs1_D) || (hz.Rd_E == hz.Rs2_D));
            case (state_r)
                ST_IDLE: begin
                    mc_stall_s = hz.McStartE;
                    mc_done_s  = 1'b0;
                    busy_s     = 1'b0;
                end
                ST_BUSY: begin
                    mc_stall_s = (cnt_r > 8'd1);
                    mc_done_s  = (cnt_r == 8'd1);
                    busy_s     = 1'b1;
                end
                default: begin
                    mc_stall_s = 1'b0;
                    mc_done_s  = 1'b0;
                    busy_s     = 1'b0;
                end
            endcase
        end
    end

    // A held multi-cycle op in E must never be cleared, so mcStall masks both flushes
    assign stall_f_s = lw_stall_s | mc_stall_s;
    assign stall_e_s = mc_stall_s;
    assign flush_d_s = (~rst) & hz.PCSrcE & ~mc_stall_s;
    assign flush_e_s = (~rst) & (lw_stall_s | hz.PCSrcE) & ~mc_stall_s;

    assign hz.ForwardAE = fwd_a_s;
    assign hz.ForwardBE = fwd_b_s;
    assign hz.StallF    = stall_f_s;
    assign hz.StallD    = stall_f_s;
    assign hz.StallE    = stall_e_s;
    assign hz.FlushD    = flush_d_s;
    assign hz.FlushE    = flush_e_s;
    assign hz.BubbleM   = mc_stall_s;
    assign hz.McBusy    = busy_s;
    assign hz.McDoneE   = mc_done_s;

`ifdef HAZ_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_cycles_r;
    logic [CNT_W-1:0] flush_events_r;

    // Saturating perf counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_r <= {CNT_W{1'b0}};
            flush_events_r <= {CNT_W{1'b0}};
        end else begin
            if (stall_f_s && (stall_cycles_r != CNT_MAX)) begin
                stall_cycles_r <= stall_cycles_r + CNT_ONE;
            end else begin
                stall_cycles_r <= stall_cycles_r;
            end
            if (flush_d_s && (flush_events_r != CNT_MAX)) begin
                flush_events_r <= flush_events_r + CNT_ONE;
            end else begin
                flush_events_r <= flush_events_r;
            end
        end
    end

    assign hz.stall_cycles = stall_cycles_r;
    assign hz.flush_events = flush_events_r;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed + randomized bench for hazard_ctrl against a cycle-position reference model.
module tb_hazard_ctrl;
    localparam int L = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // reference model state: whether an op occupies E and how many cycles it has spent there
    bit   m_active = 1'b0;
    int   m_elapsed = 0;
    int   m_stall_cnt = 0;
    int   m_flush_cnt = 0;

    hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) hz ();

    hazard_ctrl #(.REG_AW(5), .MC_LATENCY(L), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input int rs);
        if (hz.RegWriteM && hz.Rd_M != 0 && int'(hz.Rd_M) == rs) return 2'b10;
        if (hz.RegWriteW && hz.Rd_W != 0 && int'(hz.Rd_W) == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic drive(input logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
                         input logic ld, wm, ww, br, mc);
        hz.Rs1_D = rs1d; hz.Rs2_D = rs2d; hz.Rs1_E = rs1e; hz.Rs2_E = rs2e;
        hz.Rd_E = rde;   hz.Rd_M = rdm;   hz.Rd_W = rdw;
        hz.LoadE = ld; hz.RegWriteM = wm; hz.RegWriteW = ww;
        hz.PCSrcE = br; hz.McStartE = mc;
    endtask

    // check every output for the inputs currently applied, then advance the model past the next edge
    task automatic step(input string tag);
        bit   in_op, stall, done, lw, fd, fe;
        int   pos;
        logic [1:0] fa, fb;
        in_op = m_active || hz.McStartE;
        pos   = m_active ? m_elapsed : 0;
        stall = in_op && (pos < L - 1);
        done  = in_op && (pos == L - 1);
        lw    = hz.LoadE && hz.Rd_E != 0 && (hz.Rd_E == hz.Rs1_D || hz.Rd_E == hz.Rs2_D);
        fa    = ref_fwd(int'(hz.Rs1_E));
        fb    = ref_fwd(int'(hz.Rs2_E));
        fd    = hz.PCSrcE && !stall;
        fe    = (lw || hz.PCSrcE) && !stall;
        if (rst) begin
            stall = 0; done = 0; lw = 0; fd = 0; fe = 0; fa = 2'b00; fb = 2'b00;
        end
        #1;
        chk({tag, ".ForwardAE"}, 32'(hz.ForwardAE), 32'(fa));
        chk({tag, ".ForwardBE"}, 32'(hz.ForwardBE), 32'(fb));
        chk({tag, ".StallF"},    32'(hz.StallF),    32'(lw || stall));
        chk({tag, ".StallD"},    32'(hz.StallD),    32'(lw || stall));
        chk({tag, ".StallE"},    32'(hz.StallE),    32'(stall));
        chk({tag, ".BubbleM"},   32'(hz.BubbleM),   32'(stall));
        chk({tag, ".FlushD"},    32'(hz.FlushD),    32'(fd));
        chk({tag, ".FlushE"},    32'(hz.FlushE),    32'(fe));
        chk({tag, ".McBusy"},    32'(hz.McBusy),    32'(!rst && m_active));
        chk({tag, ".McDoneE"},   32'(hz.McDoneE),   32'(done));
`ifdef HAZ_PERF_CNT_EN
        chk({tag, ".stall_cycles"}, hz.stall_cycles, 32'(m_stall_cnt));
        chk({tag, ".flush_events"}, hz.flush_events, 32'(m_flush_cnt));
`endif
        if (rst) begin
            m_active = 0; m_elapsed = 0; m_stall_cnt = 0; m_flush_cnt = 0;
        end else begin
            if (lw || stall) m_stall_cnt++;
            if (fd) m_flush_cnt++;
            if (in_op) begin
                if (pos == L - 1) begin
                    m_active = 0; m_elapsed = 0;
                end else begin
                    m_active = 1; m_elapsed = pos + 1;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        drive(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // reset dominates everything, including a matching forward
        rst = 1'b1;
        drive(5'd7, 5'd7, 5'd5, 5'd5, 5'd7, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step("reset");
        chk("reset.McStartE_ignored", 32'(hz.McBusy), 32'd0);
        step("reset2");
        rst = 1'b0;
        drive(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("post_reset");

        // forwarding priority
        drive(5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        #1 chk("fwd_m_prio", 32'(hz.ForwardAE), 32'h2);
        step("fwd_m");
        drive(5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        #1 chk("fwd_w", 32'(hz.ForwardAE), 32'h1);
        step("fwd_w");
        drive(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step("fwd_x0");
        drive(5'd0, 5'd0, 5'd3, 5'd9, 5'd0, 5'd9, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step("fwd_split");

        // load-use, then x0 destination
        drive(5'd1, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 chk("lw_stall", 32'({hz.StallF, hz.StallD, hz.FlushE}), 32'h7);
        step("lw");
        drive(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("lw_x0");

        // branch alone
        drive(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1 chk("branch", 32'({hz.FlushD, hz.FlushE, hz.StallF, hz.StallE}), 32'hC);
        step("branch");

        // load-use and branch together
        drive(5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step("lw_branch");

        // 4-cycle op with branch in cycle 1
        drive(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("mc_c0");
        hz.PCSrcE = 1'b1;
        #1 chk("mc_c1_noflush", 32'({hz.FlushD, hz.FlushE}), 32'h0);
        step("mc_c1");
        hz.PCSrcE = 1'b0;
        step("mc_c2");
        #1 chk("mc_c3_done", 32'(hz.McDoneE), 32'h1);
        step("mc_c3");
        hz.McStartE = 1'b0;
        #1 chk("mc_c4_idle", 32'(hz.McBusy), 32'h0);
        step("mc_c4");

        // reset during cycle 2 of an op aborts it
        hz.McStartE = 1'b1;
        step("abort_c0");
        step("abort_c1");
        rst = 1'b1;
        step("abort_rst");
        rst = 1'b0;
        hz.McStartE = 1'b0;
        #1 chk("abort_idle", 32'({hz.McBusy, hz.McDoneE}), 32'h0);
        step("abort_after");

        // perf: three load-use stalls and two branch flushes after a reset
        rst = 1'b1;
        step("perf_rst");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(5'd4, 5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            step("perf_lw");
        end
        for (int i = 0; i < 2; i++) begin
            drive(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            step("perf_br");
        end
        drive(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef HAZ_PERF_CNT_EN
        #1 chk("perf_totals", {hz.stall_cycles[15:0], hz.flush_events[15:0]}, 32'h0003_0002);
`endif
        step("perf_end");

        // randomized traffic over a narrow register range to provoke matches
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 5) == 0));
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised successor to the forwarding-only hazard unit of the 5-stage RISC-V pipeline.
- Adds the following on top of M/W→E operand forwarding:
  - load-use stall detection
  - branch/jump flush
  - a multi-cycle execute-op sequencer (MUL/DIV-class) that holds E for a configurable latency and bubbles M.
- Sits beside the stage modules; drives stall/flush/bubble controls into every pipeline register.

Parameters:
- REG_AW, 5, register-address width. x0 is the all-zero address.
- MC_LATENCY, 4, cycles a multi-cycle op occupies E. Legal range is 2..255.
- CNT_W, 32, perf-counter width. Used only with HAZ_PERF_CNT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- Rs1_D  in  REG_AW  source 1 of the instruction in D.
- Rs2_D  in  REG_AW  source 2 of the instruction in D.
- Rs1_E  in  REG_AW  source 1 of the instruction in E.
- Rs2_E  in  REG_AW  source 2 of the instruction in E.
- Rd_E  in  REG_AW  destination of the instruction in E.
- Rd_M  in  REG_AW  destination of the instruction in M.
- Rd_W  in  REG_AW  destination of the instruction in W.
- LoadE  in  1  instruction in E is a load (ResultSrcE == 2'b01).
- RegWriteM  in  1  instruction in M writes the register file.
- RegWriteW  in  1  instruction in W writes the register file.
- PCSrcE  in  1  taken branch/jump resolved in E.
- McStartE  in  1  instruction in E is a multi-cycle op.
- ForwardAE  out  2  operand A select: 00 register file, 10 ALU_ResultM, 01 ResultW.
- ForwardBE  out  2  operand B select, same encoding as ForwardAE.
- StallF  out  1  hold PC.
- StallD  out  1  hold the F/D register.
- StallE  out  1  hold the D/E register.
- FlushD  out  1  clear the F/D register.
- FlushE  out  1  clear the D/E register (bubble into E).
- BubbleM  out  1  clear the E/M register (bubble into M).
- McBusy  out  1  sequencer in BUSY.
- McDoneE  out  1  multi-cycle result valid in E this cycle.
- stall_cycles  out  CNT_W  perf counter. Present only with the macro.
- flush_events  out  CNT_W  perf counter. Present only with the macro.

Behaviour:
- Reset:
  - rst sampled at posedge: state←IDLE, cnt←0, perf counters←0.
  - While rst is high, all control outputs are forced to 0 and ForwardAE/BE to 00, regardless of the other inputs.
  - rst asserted mid-BUSY aborts the op; no McDoneE pulse is produced.
- Forwarding (combinational), per operand X in {A,B}:
  - 10 if RegWriteM & Rd_M!=0 & Rd_M==RsX_E.
  - else 01 if RegWriteW & Rd_W!=0 & Rd_W==RsX_E.
  - else 00.
  - M has priority over W.
- Load-use: lwStall = LoadE & Rd_E!=0 & (Rd_E==Rs1_D | Rd_E==Rs2_D).
- Sequencer FSM (cnt is 8 bits):
  - IDLE & McStartE: cnt←MC_LATENCY-1, go to BUSY; mcStall=1 this cycle.
  - BUSY & cnt>1: cnt←cnt-1; mcStall=1.
  - BUSY & cnt==1: McDoneE=1, mcStall=0, go to IDLE. E advances next edge.
  - McStartE is ignored in BUSY (same held op).
  - Result: the op resides in E for exactly MC_LATENCY cycles, with McDoneE on the last one.
- Control equations:
  - StallF = StallD = lwStall | mcStall.
  - StallE = mcStall.
  - BubbleM = mcStall.
  - FlushD = PCSrcE & ~mcStall.
  - FlushE = (lwStall | PCSrcE) & ~mcStall.
  - McBusy = (state==BUSY).
- Simultaneous events:
  - mcStall overrides flushes; E holds an op, so nothing is cleared.
  - lwStall & PCSrcE: both flushes assert. The wrong-path D instruction is killed; the stall is harmless.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- Defined:
  - stall_cycles increments each cycle StallF=1.
  - flush_events increments each cycle FlushD=1.
  - Both are saturating at 2^CNT_W-1 and cleared by rst.
- Undefined: both ports and their registers are absent. All other behaviour is identical.

Test Plan:
- Reset: rst=1 with McStartE=1, PCSrcE=1 → all outputs 0; after release, McBusy=0.
- Forwarding priority: RegWriteM=RegWriteW=1, Rd_M=Rd_W=Rs1_E=5 → ForwardAE=10.
  - Then Rd_M=0 → ForwardAE=01.
  - Rs1_E=0 with Rd_M=Rd_W=0 → 00.
- Load-use: LoadE=1, Rd_E=7, Rs2_D=7 → StallF=StallD=FlushE=1 for one cycle.
  - Rd_E=0 → no stall.
- Branch: PCSrcE=1 alone → FlushD=FlushE=1, no stalls.
- Multi-cycle, MC_LATENCY=4: McStartE=1 at cycle 0 →
  - StallE=BubbleM=1 for cycles 0–2.
  - McDoneE=1 at cycle 3 only; IDLE at cycle 4.
  - PCSrcE=1 during cycle 1 → FlushD=FlushE=0.
- Reset mid-op plus perf: rst at cycle 2 of a 4-cycle op → no McDoneE, IDLE after reset.
  - With HAZ_PERF_CNT_EN: three load-use stalls plus two branch flushes → stall_cycles=3, flush_events=2.
